// File: rtl/fetch_sequencer.sv
// Fetch PC owner: single-outstanding imem req/gnt/rvalid, fixed-priority redirect with squash.
// 3 cycles per instruction with zero-wait memory; decode stalls hold the fetched word in HOLD.
module fetch_sequencer #(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'hBFC00000,
  parameter logic [XLEN-1:0]   TRAP_VEC = 32'hBFC00380
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_i,
  input  logic            ex_redirect_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            id_redirect_i,
  input  logic [XLEN-1:0] id_target_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  input  logic            if_ready_i,
  output logic            flush_o
);

  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, DROP} state_e;

  localparam logic [XLEN-1:0] LSB_MASK = ~{{(XLEN-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            valid_q, valid_d;
  logic            redir;
  logic            accept;
  logic [XLEN-1:0] redir_target;

  assign redir  = trap_i | ex_redirect_i | id_redirect_i;
  assign accept = valid_q & if_ready_i & ~stall_i;

  always_comb begin
    redir_target = id_target_i & LSB_MASK;
    if (trap_i) begin
      redir_target = TRAP_VEC;
    end else if (ex_redirect_i) begin
      redir_target = ex_target_i & LSB_MASK;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (imem_gnt_i) begin
          state_d = redir ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (redir) begin
            state_d = REQ;
          end else begin
            instr_d = imem_rdata_i;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + XLEN'(4);
            state_d = HOLD;
          end
        end else if (redir) begin
          state_d = DROP;
        end
      end
      HOLD: begin
        if (redir || accept) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      DROP: begin
        if (imem_rvalid_i) begin
          state_d = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
    // A redirect overrides the sequential PC and kills whatever is held, in every state.
    if (redir) begin
      pc_d    = redir_target;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req_o  = (state_q == REQ);
  assign imem_addr_o = pc_q;
  assign if_valid_o  = valid_q;
  assign if_instr_o  = instr_q;
  assign if_pc_o     = ipc_q;
  assign flush_o     = rst & redir;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: transaction-level model of fetch order plus directed redirect scenarios.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam logic [31:0] TRAP_VEC = 32'hBFC00380;
  localparam logic [31:0] KEY      = 32'h13572468;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_i, ex_redirect_i, id_redirect_i, stall_i, if_ready_i;
  logic [31:0] ex_target_i, id_target_i;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        if_valid_o, flush_o;
  logic [31:0] if_instr_o, if_pc_o;

  fetch_sequencer #(.XLEN(32), .RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst(rst),
    .trap_i(trap_i), .ex_redirect_i(ex_redirect_i), .ex_target_i(ex_target_i),
    .id_redirect_i(id_redirect_i), .id_target_i(id_target_i), .stall_i(stall_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .if_valid_o(if_valid_o), .if_instr_o(if_instr_o), .if_pc_o(if_pc_o),
    .if_ready_i(if_ready_i), .flush_o(flush_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_mis = 0;
  int cyc = 0, rel_cyc = 0, flush_cnt = 0;
  int gnt_lat = 0, rv_lat = 1;

  logic [31:0] g_addr[$];
  int          g_cyc[$];
  logic [31:0] d_pc[$], d_ins[$];
  int          d_cyc[$];

  // Model: next fetch address, the one outstanding request, and the word held for decode.
  logic [31:0] m_pc = RESET_PC, m_hpc = '0, m_hins = '0, m_oaddr = '0;
  bit          m_valid = 0, m_out = 0, m_sq = 0;
  bit          redir, accept, prev_rst = 0;
  logic [31:0] tgt;

  bit          mem_pending = 0, mem_granted = 0;
  int          mem_cnt = 0, mem_req_cnt = 0;
  logic [31:0] mem_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ga(input int i);
    return (i < g_addr.size()) ? g_addr[i] : 32'hxxxxxxxx;
  endfunction
  function automatic int gc(input int i);
    return (i < g_cyc.size()) ? g_cyc[i] : -1;
  endfunction
  function automatic logic [31:0] dp(input int i);
    return (i < d_pc.size()) ? d_pc[i] : 32'hxxxxxxxx;
  endfunction
  function automatic logic [31:0] di(input int i);
    return (i < d_ins.size()) ? d_ins[i] : 32'hxxxxxxxx;
  endfunction
  function automatic int dc(input int i);
    return (i < d_cyc.size()) ? d_cyc[i] : -1;
  endfunction

  // Memory stub: grants after gnt_lat request cycles, answers rv_lat cycles after the grant.
  initial begin
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
    forever begin
      @(negedge clk); #1;
      imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 32'hDEADBEEF;
      if (mem_granted) begin mem_pending = 1; mem_cnt = rv_lat; mem_granted = 0; end
      if (mem_pending) begin
        if (mem_cnt <= 1) begin
          imem_rvalid_i = 1; imem_rdata_i = mem_addr ^ KEY; mem_pending = 0;
        end else mem_cnt--;
      end
      if (imem_req_o && !mem_pending) begin
        if (mem_req_cnt >= gnt_lat) begin
          imem_gnt_i = 1; mem_granted = 1; mem_addr = imem_addr_o; mem_req_cnt = 0;
        end else mem_req_cnt++;
      end else mem_req_cnt = 0;
    end
  end

  // Compare process: checks outputs just before each rising edge, then advances the model.
  initial begin
    forever begin
      @(negedge clk); #3;
      cyc++;
      if (!rst) begin
        chk("reset_outputs", {27'd0, imem_req_o, if_valid_o, flush_o, |if_instr_o, |if_pc_o}, 32'd0);
        m_pc = RESET_PC; m_valid = 0; m_out = 0; m_sq = 0;
      end else begin
        if (!prev_rst) rel_cyc = cyc;
        redir = trap_i | ex_redirect_i | id_redirect_i;
        tgt   = trap_i ? TRAP_VEC : ex_redirect_i ? {ex_target_i[31:1], 1'b0} : {id_target_i[31:1], 1'b0};
        chk1("flush", flush_o, redir);
        if (flush_o) flush_cnt++;
        chk1("if_valid", if_valid_o, m_valid);
        if (m_valid) begin
          chk("if_pc", if_pc_o, m_hpc);
          chk("if_instr", if_instr_o, m_hins);
        end
        if (imem_req_o) begin
          chk("req_addr", imem_addr_o, m_pc);
          chk1("req_while_busy", m_out | m_valid, 1'b0);
        end
        accept = m_valid && if_ready_i && !stall_i;
        if (accept && !redir) begin
          d_pc.push_back(m_hpc); d_ins.push_back(m_hins); d_cyc.push_back(cyc);
        end
        if (accept) m_valid = 0;
        if (m_out && imem_rvalid_i) begin
          m_out = 0;
          if (!m_sq && !redir) begin
            m_valid = 1; m_hpc = m_oaddr; m_hins = imem_rdata_i; m_pc = m_oaddr + 32'd4;
          end
        end
        if (imem_req_o && imem_gnt_i) begin
          m_out = 1; m_sq = 0; m_oaddr = imem_addr_o;
          g_addr.push_back(imem_addr_o); g_cyc.push_back(cyc);
        end
        if (redir) begin
          m_pc = tgt; m_valid = 0;
          if (m_out) m_sq = 1;
        end
      end
      prev_rst = rst;
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_grants(input int n);
    int b;
    b = 0;
    while (g_addr.size() < n && b < 80) begin tick(); b++; end
    n_vec++;
    if (g_addr.size() < n) begin
      n_mis++; $display("FAIL grant_timeout: got %0d grants, need %0d", g_addr.size(), n);
    end
  endtask

  task automatic wait_delivs(input int n);
    int b;
    b = 0;
    while (d_pc.size() < n && b < 80) begin tick(); b++; end
    n_vec++;
    if (d_pc.size() < n) begin
      n_mis++; $display("FAIL deliver_timeout: got %0d deliveries, need %0d", d_pc.size(), n);
    end
  endtask

  task automatic wait_held();
    int b;
    b = 0;
    while (if_valid_o !== 1'b1 && b < 80) begin tick(); b++; end
    chk1("held_timeout", if_valid_o, 1'b1);
  endtask

  // One-cycle redirect; returns the grant/delivery counts as of the end of the redirect cycle.
  task automatic do_redir(input bit t, input bit e, input logic [31:0] et, input bit i,
                          input logic [31:0] it, output int ng, output int nd);
    int f0;
    f0 = flush_cnt;
    trap_i = t; ex_redirect_i = e; ex_target_i = et; id_redirect_i = i; id_target_i = it;
    tick();
    trap_i = 0; ex_redirect_i = 0; id_redirect_i = 0;
    ng = g_addr.size(); nd = d_pc.size();
    tick();
    chk("flush_pulses", flush_cnt - f0, 32'd1);
  endtask

  int ng, nd, h, b;

  initial begin
    rst = 0; trap_i = 0; ex_redirect_i = 0; id_redirect_i = 0;
    ex_target_i = '0; id_target_i = '0; stall_i = 0; if_ready_i = 1;
    repeat (3) tick();
    rst = 1;

    // Sequential fetch from reset, zero-wait memory.
    wait_grants(3);
    wait_delivs(3);
    chk("t1_addr0", ga(0), 32'hBFC00000);
    chk("t1_addr1", ga(1), 32'hBFC00004);
    chk("t1_addr2", ga(2), 32'hBFC00008);
    chk("t1_first_req_cycle", gc(0), rel_cyc + 1);
    chk("t1_cadence01", gc(1) - gc(0), 32'd3);
    chk("t1_cadence12", gc(2) - gc(1), 32'd3);
    chk("t1_pc0", dp(0), 32'hBFC00000);
    chk("t1_pc1", dp(1), 32'hBFC00004);
    chk("t1_pc2", dp(2), 32'hBFC00008);
    chk("t1_instr0", di(0), 32'hAC972468);

    // Hold under stall for 4 cycles, accepted on the 5th.
    stall_i = 1;
    do_redir(0, 0, '0, 1, 32'h00001000, ng, nd);
    wait_held();
    h = cyc + 1;
    repeat (4) tick();
    stall_i = 0;
    wait_delivs(nd + 1);
    chk("t2_pc", dp(nd), 32'h00001000);
    chk("t2_instr", di(nd), 32'h13573468);
    chk("t2_accept_cycle", dc(nd), h + 4);
    wait_grants(ng + 2);
    chk("t2_first_addr", ga(ng), 32'h00001000);
    chk("t2_next_addr", ga(ng + 1), 32'h00001004);

    // Execute redirect while waiting for a response; that response must be dropped.
    rv_lat = 2;
    wait_grants(g_addr.size() + 1);
    do_redir(0, 1, 32'h80000011, 0, '0, ng, nd);
    wait_grants(ng + 1);
    wait_delivs(nd + 1);
    chk("t3_addr", ga(ng), 32'h80000010);
    chk("t3_pc", dp(nd), 32'h80000010);

    // Redirect in HOLD while decode would also accept: held word is not delivered.
    rv_lat = 1;
    wait_held();
    do_redir(0, 0, '0, 1, 32'h00002000, ng, nd);
    wait_delivs(nd + 1);
    chk("t3b_pc", dp(nd), 32'h00002000);

    // Redirect in REQ before grant; bit 1 of the target passes, bit 0 cleared.
    gnt_lat = 2;
    b = 0;
    while (imem_req_o && b < 40) begin tick(); b++; end
    while (!imem_req_o && b < 80) begin tick(); b++; end
    do_redir(0, 1, 32'h00003003, 0, '0, ng, nd);
    wait_grants(ng + 1);
    chk("t3c_addr", ga(ng), 32'h00003002);
    gnt_lat = 0;

    // All three sources at once: trap wins, one flush.
    do_redir(1, 1, 32'h00000100, 1, 32'h00000200, ng, nd);
    wait_grants(ng + 1);
    chk("t4_addr", ga(ng), 32'hBFC00380);

    // PC wraps past the top of the address space.
    do_redir(0, 0, '0, 1, 32'hFFFFFFFC, ng, nd);
    wait_grants(ng + 2);
    wait_delivs(nd + 1);
    chk("t5_addr", ga(ng), 32'hFFFFFFFC);
    chk("t5_instr", di(nd), 32'hECA8DB94);
    chk("t5_wrap_addr", ga(ng + 1), 32'h00000000);

    // Asynchronous reset while waiting; the late response lands while in REQ.
    rv_lat = 3;
    wait_grants(g_addr.size() + 1);
    rst = 0;
    #1;
    chk1("t6_req_drop", imem_req_o, 1'b0);
    chk1("t6_valid_drop", if_valid_o, 1'b0);
    chk("t6_if_pc_clear", if_pc_o, 32'd0);
    chk("t6_if_instr_clear", if_instr_o, 32'd0);
    tick();
    rst = 1;
    ng = g_addr.size(); nd = d_pc.size();
    wait_grants(ng + 1);
    wait_delivs(nd + 1);
    chk("t6_restart_addr", ga(ng), 32'hBFC00000);
    chk("t6_restart_cycle", gc(ng), rel_cyc + 1);
    chk("t6_restart_pc", dp(nd), 32'hBFC00000);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction fetch for the core: owns the fetch PC, drives a single-outstanding request/grant/response handshake to instruction memory, and presents fetched instructions to decode with valid/ready.
- Arbitrates PC redirect sources by fixed priority: trap > execute-stage branch/jalr > decode-stage jal > sequential PC+4.
- On redirect, squashes stale in-flight responses and pulses a pipeline flush.
- Replaces the bare PCSrc-selected PC register in the fetch stage.

Parameters:
- XLEN, 32, address and instruction width.
- RESET_PC, 32'hBFC00000, first fetch address after reset.
- TRAP_VEC, 32'hBFC00380, redirect target when trap_i is asserted.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- trap_i  input  1  trap redirect request; target is TRAP_VEC.
- ex_redirect_i  input  1  execute-stage taken branch or jalr.
- ex_target_i  input  XLEN  execute redirect target; bit 0 forced to 0 internally.
- id_redirect_i  input  1  decode-stage jal redirect.
- id_target_i  input  XLEN  decode redirect target; bit 0 forced to 0.
- stall_i  input  1  hazard-unit stall; blocks decode acceptance.
- imem_req_o  output  1  fetch request valid.
- imem_addr_o  output  XLEN  fetch address; equals pc_q.
- imem_gnt_i  input  1  request accepted by memory.
- imem_rvalid_i  input  1  response valid for the granted request.
- imem_rdata_i  input  XLEN  response instruction word.
- if_valid_o  output  1  instruction held for decode.
- if_instr_o  output  XLEN  held instruction.
- if_pc_o  output  XLEN  PC of the held instruction.
- if_ready_i  input  1  decode ready.
- flush_o  output  1  one-cycle flush pulse, combinational, asserted in the cycle a redirect is applied.

Behaviour:
- Reset (rst=0, asynchronous): pc_q=RESET_PC, state=BOOT, imem_req_o=0, if_valid_o=0, if_instr_o=0, if_pc_o=0, flush_o=0. Assertion mid-transaction drops req immediately; any later response is ignored (state is BOOT).
- States: BOOT, REQ, WAIT, HOLD, DROP.
- BOOT: one cycle after reset release, then go to REQ.
- REQ: imem_req_o=1, imem_addr_o=pc_q; address held stable until imem_gnt_i. On gnt, go to WAIT.
- WAIT: imem_req_o=0. On rvalid: register if_instr_o=rdata, if_pc_o=pc_q, if_valid_o=1 (visible next cycle); pc_q<=pc_q+4, modulo 2^32 (0xFFFFFFFC wraps to 0); go to HOLD.
- HOLD: accept = if_valid_o & if_ready_i & ~stall_i. On accept: if_valid_o<=0, go to REQ. Otherwise hold all outputs stable.
- Minimum sequential cadence: REQ -> WAIT -> HOLD -> REQ, 3 cycles per instruction with zero-wait memory.
- Redirect (redir = trap_i | ex_redirect_i | id_redirect_i) is evaluated every non-reset cycle, including BOOT.
  - Target priority: trap_i > ex_redirect_i > id_redirect_i; lower sources are ignored when a higher one is active.
  - Effects: pc_q<=target; flush_o=1 in the same cycle; if_valid_o<=0.
- Next state on redirect:
  - BOOT, or REQ without gnt: go to REQ (request withdrawn; new address next cycle).
  - REQ with gnt in the same cycle: go to DROP.
  - WAIT without rvalid: go to DROP.
  - WAIT with rvalid: discard the data, go to REQ.
  - HOLD, including when accept is also true: held instruction is discarded, not delivered; go to REQ.
  - DROP: update pc_q, stay in DROP.
- DROP: imem_req_o=0. On rvalid, discard the data and go to REQ. A redirect in the same cycle updates pc_q; next state is still REQ.
- Target bit 0 is always cleared; bit 1 passes unmodified (no misalignment trap in this block).
- imem_rvalid_i outside WAIT/DROP is ignored. At most one request is outstanding at any time.

Test Plan:
1. Release reset, zero-wait memory (gnt in same cycle as req, rvalid next cycle), if_ready=1 -> first request at 0xBFC00000 on the cycle after BOOT; if_pc_o sequence 0xBFC00000, 0xBFC00004, 0xBFC00008, one instruction every 3 cycles.
2. HOLD with if_ready=1 and stall_i=1 for 4 cycles, then stall_i=0 -> if_instr_o/if_pc_o stable for 4 cycles; accepted on the 5th; next req at +4.
3. Redirect mid-flight: ex_redirect_i=1, target 0x80000011, in the WAIT state, rvalid arrives 2 cycles later -> flush_o pulses one cycle; that response is discarded (if_valid_o stays 0); next req addr is 0x80000010.
4. Same cycle trap_i=1, ex_redirect_i=1 (target 0x100), id_redirect_i=1 (target 0x200) -> pc_q=0xBFC00380; a single flush_o pulse.
5. pc_q=0xFFFFFFFC fetch completes -> next request address 0x00000000.
6. Assert rst=0 asynchronously while in WAIT -> imem_req_o and if_valid_o drop before the next clock edge; a late rvalid is ignored; after release, fetch restarts at 0xBFC00000.
